// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter on the CPU byte bus.
//                Bytes written to TXDATA are queued in a small FIFO and
//                shifted out LSB first on tx. STATUS and the baud divisor
//                are readable through a registered read port.
//  Ports       : clk          system clock, rising edge
//                rst          asynchronous, active-low reset
//                address      byte address from the CPU
//                write_data   write byte from the CPU
//                write_enable write strobe, one write per asserted cycle
//                read_data    registered read data, 8'h00 when not selected
//                sel          combinational window hit (BASE_ADDR..BASE_ADDR+3)
//                tx           serial line, idle high
//                irq          (UART_TX_IRQ_EN only) registered interrupt:
//                             FIFO empty and transmitter idle, masked by ie
//  Register map: +0 TXDATA  W push byte / R 8'h00
//                +1 STATUS  R {ie, 3'b0, overflow, busy, empty, full}
//                           W clears overflow (and loads ie when enabled)
//                +2 DIVLO   R/W divisor[7:0]
//                +3 DIVHI   R/W divisor[15:8]
//  Config macro: UART_TX_IRQ_EN adds the irq output and the ie bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [7:0]  write_data,
  input  logic        write_enable,
  output logic [7:0]  read_data,
  output logic        sel,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int               c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_overflow;
  logic [15:0]        r_div;
  logic [7:0]         r_read_data;
  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_tx;
  logic               r_ie;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_wr_txdata;
  logic        w_wr_status;
  logic        w_wr_divlo;
  logic        w_wr_divhi;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_bit_end;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [15:0] w_bit_len;
  logic [7:0]  w_head;
  logic [7:0]  w_status;

  assign w_sel = (address >= BASE_ADDR) && (address <= (BASE_ADDR + 32'd3));
  // Only the low two bits of the difference matter inside a 4-byte window.
  assign w_off = address[1:0] - BASE_ADDR[1:0];

  assign w_wr_txdata = w_sel && write_enable && (w_off == 2'd0);
  assign w_wr_status = w_sel && write_enable && (w_off == 2'd1);
  assign w_wr_divlo  = w_sel && write_enable && (w_off == 2'd2);
  assign w_wr_divhi  = w_sel && write_enable && (w_off == 2'd3);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_cnt == 16'd0);
  assign w_head    = r_mem[r_rd_ptr];

  // The FSM consumes the head either from IDLE or at the last cycle of STOP
  // (back-to-back frames).
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign w_push = w_wr_txdata && (!w_full || w_pop);
  assign w_drop = w_wr_txdata && w_full && !w_pop;

  // Down-counter reload value; a divisor of 0 behaves like 1.
  assign w_bit_len = (r_div == 16'd0) ? 16'd0 : (r_div - 16'd1);

  assign w_status = {r_ie, 3'b000, r_overflow, w_busy, w_empty, w_full};

  assign sel       = w_sel;
  assign read_data = r_read_data;
  assign tx        = r_tx;

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed: validity is tracked by r_count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control registers and registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_div       <= DIV_RESET;
      r_read_data <= 8'h00;
    end else begin
      if (w_wr_status) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_divlo) r_div[7:0]  <= write_data;
      if (w_wr_divhi) r_div[15:8] <= write_data;

      if (!w_sel) begin
        r_read_data <= 8'h00;
      end else begin
        case (w_off)
          2'd1:    r_read_data <= w_status;
          2'd2:    r_read_data <= r_div[7:0];
          2'd3:    r_read_data <= r_div[15:8];
          default: r_read_data <= 8'h00;
        endcase
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_status) r_ie <= write_data[7];
      r_irq <= r_ie && w_empty && (r_state == S_IDLE);
    end
  end

  assign irq = r_irq;
`else
  assign r_ie = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Transmit FSM. r_cnt counts down the current bit period and is reloaded
  // from the live divisor at every bit start, so divisor writes take effect
  // on the next bit boundary.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_cnt     <= 16'd0;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_cnt   <= w_bit_len;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'd0;
            r_cnt     <= w_bit_len;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= w_bit_len;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_cnt   <= w_bit_len;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx. Transmitted
//                bytes are queued in a scoreboard when written; the serial
//                line is logged every cycle and decoded against the queue
//                using the bit periods the bench itself programmed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = 32'h0;
  logic [7:0]  write_data = 8'h00;
  logic        write_enable = 1'b0;
  logic [7:0]  read_data;
  logic        sel;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd434)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .sel          (sel),
    .tx           (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  bit         txlog[$];
  bit         log_en = 1'b0;

  always @(negedge clk) begin
    if (log_en) txlog.push_back(tx);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
    address      = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [7:0] d);
    address      = a;
    write_enable = 1'b0;
    @(negedge clk);
    d       = read_data;
    address = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    chk(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic send(input logic [7:0] b);
    sb.push_back(b);
    wr(BASE, b);
  endtask

  task automatic start_log();
    txlog.delete();
    log_en = 1'b1;
  endtask

  // Decode nframes from the log. Bits of frame 0 below chg_bit last div
  // cycles; every later bit lasts new_div cycles. With contiguous set, each
  // frame after the first must start on the cycle right after the stop bit.
  task automatic check_log(input int nframes, input int div, input int chg_bit,
                           input int new_div, input bit contiguous, input string tag);
    int         idx;
    int         per;
    int         nb;
    logic [9:0] pat;
    logic [7:0] e;
    log_en = 1'b0;
    idx = 0;
    for (int f = 0; f < nframes; f++) begin
      if (f == 0 || !contiguous) begin
        while (idx < txlog.size() && txlog[idx] == 1'b1) idx++;
      end
      e   = (sb.size() > 0) ? sb.pop_front() : 8'h00;
      pat = {1'b1, e, 1'b0};
      for (int b = 0; b < 10; b++) begin
        per = (f == 0 && b < chg_bit) ? div : new_div;
        nb  = 0;
        for (int c = 0; c < per; c++) begin
          if (idx >= txlog.size()) nb++;
          else if (txlog[idx] != pat[b]) nb++;
          idx++;
        end
        chk($sformatf("%s_f%0d_bit%0d_badcycles", tag, f, b), nb, 0);
      end
    end
    nb = 0;
    while (idx < txlog.size()) begin
      if (txlog[idx] == 1'b0) nb++;
      idx++;
    end
    chk($sformatf("%s_idle_low_cycles", tag), nb, 0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_read_data", {24'h0, read_data}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rd_chk("rst_status", BASE + 32'd1, 8'h02);
    rd_chk("rst_divlo",  BASE + 32'd2, 8'hB2);
    rd_chk("rst_divhi",  BASE + 32'd3, 8'h01);
    rd_chk("rd_txdata",  BASE,         8'h00);
    rd_chk("rd_outside", BASE + 32'd4, 8'h00);
    address = BASE + 32'd3; #1;
    chk("sel_top", {31'h0, sel}, 32'h1);
    address = BASE + 32'd4; #1;
    chk("sel_above", {31'h0, sel}, 32'h0);
    address = BASE - 32'd1; #1;
    chk("sel_below", {31'h0, sel}, 32'h0);
    @(negedge clk);

    // ---------------- single frame, divisor 4 ----------------
    wr(BASE + 32'd2, 8'd4);
    wr(BASE + 32'd3, 8'd0);
    start_log();
    send(8'hA5);
    repeat (4) @(negedge clk);
    rd_chk("a5_status_busy", BASE + 32'd1, 8'h06);
    repeat (50) @(negedge clk);
    check_log(1, 4, 10, 4, 1'b0, "a5");
    rd_chk("a5_status_idle", BASE + 32'd1, 8'h02);

    // ---------------- back-to-back, divisor 2 ----------------
    wr(BASE + 32'd2, 8'd2);
    start_log();
    send(8'h11);
    send(8'hC3);
    send(8'h7E);
    repeat (80) @(negedge clk);
    check_log(3, 2, 10, 2, 1'b1, "b2b");

    // ---------------- FIFO full / overflow, divisor 100 ----------------
    wr(BASE + 32'd2, 8'd100);
    start_log();
    send(8'h01);
    send(8'h02);
    send(8'h04);
    send(8'h08);
    send(8'h10);
    wr(BASE, 8'hEE);                       // FIFO full: must be dropped
    rd_chk("ovf_status_set", BASE + 32'd1, 8'h0D);
    wr(BASE + 32'd1, 8'h00);
    rd_chk("ovf_status_clr", BASE + 32'd1, 8'h05);
    repeat (5100) @(negedge clk);
    check_log(5, 100, 10, 100, 1'b1, "fifo");
    rd_chk("fifo_status_idle", BASE + 32'd1, 8'h02);

    // ---------------- writes outside the window ----------------
    start_log();
    wr(BASE + 32'd4, 8'h55);
    wr(BASE - 32'd1, 8'h55);
    repeat (20) @(negedge clk);
    check_log(0, 1, 10, 1, 1'b0, "outside");
    rd_chk("outside_divlo", BASE + 32'd2, 8'd100);

    // ---------------- divisor 0 behaves as 1 ----------------
    wr(BASE + 32'd2, 8'd0);
    start_log();
    send(8'h81);
    repeat (20) @(negedge clk);
    check_log(1, 1, 10, 1, 1'b0, "div0");

    // ---------------- divisor change mid-frame ----------------
    wr(BASE + 32'd2, 8'd6);
    start_log();
    send(8'h3C);
    repeat (8) @(negedge clk);
    wr(BASE + 32'd2, 8'd3);                // lands inside data bit 0
    repeat (60) @(negedge clk);
    check_log(1, 6, 2, 3, 1'b0, "divchg");

    // ---------------- reset mid-frame ----------------
    wr(BASE + 32'd2, 8'd100);
    wr(BASE, 8'hF0);
    wr(BASE, 8'h0F);
    repeat (150) @(negedge clk);
    chk("midrst_pre_tx", {31'h0, tx}, 32'h0);
    address = BASE + 32'd1;
    @(negedge clk);
    chk("midrst_pre_status", {24'h0, read_data}, 32'h04);
    #2 rst = 1'b0;
    #1;
    chk("midrst_tx", {31'h0, tx}, 32'h1);
    chk("midrst_read_data", {24'h0, read_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    address = 32'h0;
    @(negedge clk);
    rd_chk("midrst_status", BASE + 32'd1, 8'h02);
    rd_chk("midrst_divlo",  BASE + 32'd2, 8'hB2);
    rd_chk("midrst_divhi",  BASE + 32'd3, 8'h01);
    start_log();
    repeat (40) @(negedge clk);
    check_log(0, 1, 10, 1, 1'b0, "flushed");

`ifdef UART_TX_IRQ_EN
    // ---------------- interrupt ----------------
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(BASE + 32'd1, 8'h80);
    @(negedge clk);
    chk("irq_idle", {31'h0, irq}, 32'h1);
    rd_chk("irq_status", BASE + 32'd1, 8'h82);
    wr(BASE + 32'd2, 8'd2);
    wr(BASE + 32'd3, 8'd0);
    start_log();
    send(8'h5A);
    @(negedge clk);
    chk("irq_busy", {31'h0, irq}, 32'h0);
    repeat (30) @(negedge clk);
    chk("irq_done", {31'h0, irq}, 32'h1);
    check_log(1, 2, 10, 2, 1'b0, "irq");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
